// File: rtl/player_motion_pkg.sv
// Shared encodings for the player gravity motion controller: motion states and
// gravity-direction codes.
package player_motion_pkg;

  typedef enum logic [1:0] {
    StFree     = 2'd0,
    StGrounded = 2'd1,
    StJumping  = 2'd2,
    StFalling  = 2'd3
  } motion_state_t;

  localparam logic [2:0] GRAV_NONE  = 3'd0;
  localparam logic [2:0] GRAV_UP    = 3'd1;
  localparam logic [2:0] GRAV_RIGHT = 3'd2;
  localparam logic [2:0] GRAV_DOWN  = 3'd3;
  localparam logic [2:0] GRAV_LEFT  = 3'd4;

  // Unused codes collapse onto "no gravity".
  function automatic logic [2:0] decode_dir(input logic [2:0] dir);
    return (dir > GRAV_LEFT) ? GRAV_NONE : dir;
  endfunction

endpackage

// File: rtl/player_gravity_axis_map.sv
// Maps a decoded gravity direction onto the gravity axis, its floor/ceiling box
// edges, the direction of fall and the key that jumps against gravity.
module player_gravity_axis_map
  import player_motion_pkg::*;
#(
  parameter int POS_W = 10
) (
  input  logic [2:0]       i_dir,
  input  logic             i_switch_up,
  input  logic             i_switch_down,
  input  logic             i_switch_left,
  input  logic             i_switch_right,
  input  logic [POS_W-1:0] i_x0,
  input  logic [POS_W-1:0] i_y0,
  input  logic [POS_W-1:0] i_x1,
  input  logic [POS_W-1:0] i_y1,
  output logic             o_axis_y,
  output logic             o_sign_pos,
  output logic             o_jump_key,
  output logic [POS_W-1:0] o_floor_edge,
  output logic [POS_W-1:0] o_ceil_edge
);

  // o_sign_pos: falling increases the coordinate on the gravity axis.
  always_comb begin
    o_axis_y     = 1'b1;
    o_sign_pos   = 1'b1;
    o_jump_key   = 1'b0;
    o_floor_edge = i_y1;
    o_ceil_edge  = i_y0;
    case (i_dir)
      GRAV_UP: begin
        o_sign_pos   = 1'b0;
        o_floor_edge = i_y0;
        o_ceil_edge  = i_y1;
        o_jump_key   = i_switch_down;
      end
      GRAV_RIGHT: begin
        o_axis_y     = 1'b0;
        o_floor_edge = i_x1;
        o_ceil_edge  = i_x0;
        o_jump_key   = i_switch_left;
      end
      GRAV_DOWN: begin
        o_jump_key = i_switch_up;
      end
      GRAV_LEFT: begin
        o_axis_y     = 1'b0;
        o_sign_pos   = 1'b0;
        o_floor_edge = i_x0;
        o_ceil_edge  = i_x1;
        o_jump_key   = i_switch_right;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/player_gravity_motion_controller.sv
// Player motion under selectable gravity: free movement, jump, fall and landing,
// with sub-pixel positions clamped to the play box every tick.
module player_gravity_motion_controller
  import player_motion_pkg::*;
#(
  parameter int POS_W          = 10,
  parameter int FRAC_BITS      = 4,
  parameter int PLAYER_POS_X   = 320,
  parameter int PLAYER_POS_Y   = 240,
  parameter int PLAYER_W       = 30,
  parameter int PLAYER_H       = 30,
  parameter int MOVE_SPEED     = 18,
  parameter int JUMP_SPEED     = 24,
  parameter int GRAVITY        = 2,
  parameter int MAX_FALL_SPEED = 35,
  parameter int JUMP_H         = 80
) (
  input  logic             clk_player_control,
  input  logic             reset,
  input  logic             switch_up,
  input  logic             switch_down,
  input  logic             switch_left,
  input  logic             switch_right,
  input  logic [POS_W-1:0] game_display_x0,
  input  logic [POS_W-1:0] game_display_y0,
  input  logic [POS_W-1:0] game_display_x1,
  input  logic [POS_W-1:0] game_display_y1,
  input  logic [2:0]       gravity_direction,
  input  logic [POS_W-1:0] collider_ground_h_player,
  input  logic             is_collider_ground_player,
  output logic [POS_W-1:0] player_pos_x,
  output logic [POS_W-1:0] player_pos_y,
  output logic [POS_W-1:0] player_w,
  output logic [POS_W-1:0] player_h,
  output logic             on_ground,
  output logic [1:0]       motion_state
);

  // Sign bit plus guard bit above the sub-pixel position: no wrap before clamping.
  localparam int SW = POS_W + FRAC_BITS + 2;

  localparam logic signed [SW-1:0] LP_SIZE_W     = SW'(PLAYER_W << FRAC_BITS);
  localparam logic signed [SW-1:0] LP_SIZE_H     = SW'(PLAYER_H << FRAC_BITS);
  localparam logic signed [SW-1:0] LP_MOVE       = SW'(MOVE_SPEED);
  localparam logic signed [SW-1:0] LP_JUMP_SPEED = SW'(JUMP_SPEED);
  localparam logic signed [SW-1:0] LP_GRAVITY    = SW'(GRAVITY);
  localparam logic signed [SW-1:0] LP_MAX_FALL   = SW'(MAX_FALL_SPEED);
  localparam logic signed [SW-1:0] LP_JUMP_H     = SW'(JUMP_H << FRAC_BITS);
  localparam logic signed [SW-1:0] LP_RESET_X    = SW'(PLAYER_POS_X << FRAC_BITS);
  localparam logic signed [SW-1:0] LP_RESET_Y    = SW'(PLAYER_POS_Y << FRAC_BITS);

  function automatic logic signed [SW-1:0] to_h(input logic [POS_W-1:0] px);
    return $signed({2'b00, px, {FRAC_BITS{1'b0}}});
  endfunction

  function automatic logic signed [SW-1:0] step(input logic dec, input logic inc);
    if (inc && !dec) return LP_MOVE;
    if (dec && !inc) return -LP_MOVE;
    return '0;
  endfunction

  function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] v,
                                                 input logic signed [SW-1:0] lo,
                                                 input logic signed [SW-1:0] hi);
    logic signed [SW-1:0] t;
    t = (v < lo) ? lo : v;
    return (t > hi) ? hi : t;
  endfunction

  motion_state_t        r_state, w_ns;
  logic signed [SW-1:0] r_hx, r_hy, r_fall_speed, r_jump_limit;
  logic signed [SW-1:0] w_nx, w_ny, w_nfs, w_njl, w_ng, w_cand, w_stop;
  logic signed [SW-1:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y, w_step_x, w_step_y;
  logic signed [SW-1:0] w_g, w_size, w_floor, w_ceil, w_edge_floor, w_col_h, w_col_floor;
  logic [2:0]           r_prev_dir, w_dir;
  logic [POS_W-1:0]     r_pos_x, r_pos_y, w_floor_edge, w_ceil_edge;
  logic                 r_on_ground, w_axis_y, w_sign_pos, w_jump_key, w_col_use;

  assign w_dir = decode_dir(gravity_direction);

  player_gravity_axis_map #(
    .POS_W(POS_W)
  ) u_axis_map (
    .i_dir         (w_dir),
    .i_switch_up   (switch_up),
    .i_switch_down (switch_down),
    .i_switch_left (switch_left),
    .i_switch_right(switch_right),
    .i_x0          (game_display_x0),
    .i_y0          (game_display_y0),
    .i_x1          (game_display_x1),
    .i_y1          (game_display_y1),
    .o_axis_y      (w_axis_y),
    .o_sign_pos    (w_sign_pos),
    .o_jump_key    (w_jump_key),
    .o_floor_edge  (w_floor_edge),
    .o_ceil_edge   (w_ceil_edge)
  );

  assign w_lo_x   = to_h(game_display_x0);
  assign w_hi_x   = to_h(game_display_x1) - LP_SIZE_W;
  assign w_lo_y   = to_h(game_display_y0);
  assign w_hi_y   = to_h(game_display_y1) - LP_SIZE_H;
  assign w_step_x = step(switch_left, switch_right);
  assign w_step_y = step(switch_up, switch_down);

  // Floor/ceiling expressed as the top-left coordinate at which the player is flush.
  assign w_g          = w_axis_y ? r_hy : r_hx;
  assign w_size       = w_axis_y ? LP_SIZE_H : LP_SIZE_W;
  assign w_edge_floor = w_sign_pos ? to_h(w_floor_edge) - w_size : to_h(w_floor_edge);
  assign w_ceil       = w_sign_pos ? to_h(w_ceil_edge) : to_h(w_ceil_edge) - w_size;
  assign w_col_h      = to_h(collider_ground_h_player);
  assign w_col_floor  = w_sign_pos ? w_col_h - w_size : w_col_h;
  assign w_col_use    = is_collider_ground_player &&
      (w_sign_pos ? (w_col_h < to_h(w_floor_edge) && w_col_floor >= w_g)
                  : (w_col_h > to_h(w_floor_edge) && w_col_floor <= w_g));
  assign w_floor      = w_col_use ? w_col_floor : w_edge_floor;

  always_comb begin
    w_ns   = r_state;
    w_nfs  = r_fall_speed;
    w_njl  = r_jump_limit;
    w_ng   = w_g;
    w_cand = w_g;
    w_stop = w_ceil;
    if (w_dir != r_prev_dir) begin
      w_ns  = (w_dir == GRAV_NONE) ? StFree : StFalling;
      w_nfs = '0;
    end else if (w_dir != GRAV_NONE) begin
      unique case (r_state)
        StGrounded: begin
          if (w_jump_key) begin
            w_ns  = StJumping;
            w_njl = w_sign_pos ? w_g - LP_JUMP_H : w_g + LP_JUMP_H;
            w_nfs = '0;
          end else if (w_g != w_floor) begin
            w_ns = StFalling;
          end
        end
        StJumping: begin
          if (!w_jump_key) begin
            w_ns = StFalling;
          end else begin
            w_cand = w_sign_pos ? w_g - LP_JUMP_SPEED : w_g + LP_JUMP_SPEED;
            // Stop at whichever of jump limit and ceiling comes first.
            if (w_sign_pos) w_stop = (r_jump_limit > w_ceil) ? r_jump_limit : w_ceil;
            else            w_stop = (r_jump_limit < w_ceil) ? r_jump_limit : w_ceil;
            if (w_sign_pos ? (w_cand <= w_stop) : (w_cand >= w_stop)) begin
              w_ng = w_stop;
              w_ns = StFalling;
            end else begin
              w_ng = w_cand;
            end
          end
        end
        StFalling: begin
          w_nfs  = (r_fall_speed + LP_GRAVITY > LP_MAX_FALL) ? LP_MAX_FALL
                                                             : r_fall_speed + LP_GRAVITY;
          w_cand = w_sign_pos ? w_g + w_nfs : w_g - w_nfs;
          if (w_sign_pos ? (w_cand >= w_floor) : (w_cand <= w_floor)) begin
            w_ng  = w_floor;
            w_ns  = StGrounded;
            w_nfs = '0;
          end else begin
            w_ng = w_cand;
          end
        end
        default: ;
      endcase
    end

    if (w_dir == GRAV_NONE) begin
      w_nx = r_hx + w_step_x;
      w_ny = r_hy + w_step_y;
    end else if (w_axis_y) begin
      w_nx = r_hx + w_step_x;
      w_ny = w_ng;
    end else begin
      w_nx = w_ng;
      w_ny = r_hy + w_step_y;
    end
    w_nx = clamp(w_nx, w_lo_x, w_hi_x);
    w_ny = clamp(w_ny, w_lo_y, w_hi_y);
  end

  always_ff @(posedge clk_player_control) begin
    if (reset) begin
      r_hx         <= LP_RESET_X;
      r_hy         <= LP_RESET_Y;
      r_pos_x      <= POS_W'(PLAYER_POS_X);
      r_pos_y      <= POS_W'(PLAYER_POS_Y);
      r_state      <= StFree;
      r_on_ground  <= 1'b0;
      r_fall_speed <= '0;
      r_jump_limit <= '0;
      r_prev_dir   <= GRAV_NONE;
    end else begin
      r_hx         <= w_nx;
      r_hy         <= w_ny;
      r_pos_x      <= r_hx[FRAC_BITS +: POS_W];
      r_pos_y      <= r_hy[FRAC_BITS +: POS_W];
      r_state      <= w_ns;
      r_on_ground  <= (w_ns == StGrounded);
      r_fall_speed <= w_nfs;
      r_jump_limit <= w_njl;
      r_prev_dir   <= w_dir;
    end
  end

  assign player_pos_x = r_pos_x;
  assign player_pos_y = r_pos_y;
  assign player_w     = POS_W'(PLAYER_W);
  assign player_h     = POS_W'(PLAYER_H);
  assign on_ground    = r_on_ground;
  assign motion_state = r_state;

endmodule

// File: tb/tb_player_gravity_motion_controller.sv
// Scoreboard bench: directed scenarios plus randomized stimulus, every tick compared
// against a behavioural model of the motion rules.
module tb_player_gravity_motion_controller;

  localparam int PW = 30, PH = 30, SC = 16;
  localparam int MOVE = 18, JS = 24, GRAV = 2, MAXF = 35, JH = 80;

  logic       clk = 1'b0;
  logic       reset, su, sd, sl, sr, col_v;
  logic [9:0] x0, y0, x1, y1, col;
  logic [2:0] gdir;
  logic [9:0] player_pos_x, player_pos_y, player_w, player_h;
  logic       on_ground;
  logic [1:0] motion_state;

  always #5 clk = ~clk;

  player_gravity_motion_controller dut (
    .clk_player_control       (clk),
    .reset                    (reset),
    .switch_up                (su),
    .switch_down              (sd),
    .switch_left              (sl),
    .switch_right             (sr),
    .game_display_x0          (x0),
    .game_display_y0          (y0),
    .game_display_x1          (x1),
    .game_display_y1          (y1),
    .gravity_direction        (gdir),
    .collider_ground_h_player (col),
    .is_collider_ground_player(col_v),
    .player_pos_x             (player_pos_x),
    .player_pos_y             (player_pos_y),
    .player_w                 (player_w),
    .player_h                 (player_h),
    .on_ground                (on_ground),
    .motion_state             (motion_state)
  );

  typedef struct { int px; int py; int og; int ms; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_hx, m_hy, m_st, m_fs, m_jl, m_prev;
  int trk_min_y;

  // Reference model: one tick of the motion rules, expected outputs pushed to the queue.
  task automatic model_step();
    int d, sgn, ax, key, sz, lead, ee, oe, g, flr, ceil_p, ng, cand, stp, c;
    exp_t e;
    if (reset) begin
      m_hx = 320 * SC; m_hy = 240 * SC; m_st = 0; m_fs = 0; m_jl = 0; m_prev = 0;
      e.px = 320; e.py = 240; e.og = 0; e.ms = 0;
      q.push_back(e);
      return;
    end
    e.px = m_hx / SC;
    e.py = m_hy / SC;
    d   = (gdir > 3'd4) ? 0 : int'(gdir);
    sgn = (d == 2 || d == 3) ? 1 : -1;
    ax  = (d == 1 || d == 3) ? 1 : 0;
    case (d)
      1: begin key = sd; ee = y0; oe = y1; end
      2: begin key = sl; ee = x1; oe = x0; end
      3: begin key = su; ee = y1; oe = y0; end
      4: begin key = sr; ee = x0; oe = x1; end
      default: begin key = 0; ee = 0; oe = 0; end
    endcase
    sz     = ax ? PH : PW;
    lead   = (sgn > 0) ? sz : 0;
    g      = ax ? m_hy : m_hx;
    c      = col;
    flr    = (ee - lead) * SC;
    if (col_v && sgn * (ee - c) > 0 && sgn * ((c - lead) * SC - g) >= 0) flr = (c - lead) * SC;
    ceil_p = (oe - (sz - lead)) * SC;
    ng     = g;
    if (d != m_prev) begin
      m_st = (d == 0) ? 0 : 3;
      m_fs = 0;
    end else if (d != 0) begin
      case (m_st)
        1: begin
          if (key) begin m_st = 2; m_jl = g - sgn * JH * SC; m_fs = 0; end
          else if (g != flr) m_st = 3;
        end
        2: begin
          if (!key) m_st = 3;
          else begin
            cand = g - sgn * JS;
            stp  = (sgn * m_jl > sgn * ceil_p) ? m_jl : ceil_p;
            if (sgn * (cand - stp) <= 0) begin ng = stp; m_st = 3; end
            else ng = cand;
          end
        end
        3: begin
          m_fs = (m_fs + GRAV > MAXF) ? MAXF : m_fs + GRAV;
          cand = g + sgn * m_fs;
          if (sgn * (cand - flr) >= 0) begin ng = flr; m_st = 1; m_fs = 0; end
          else ng = cand;
        end
        default: ;
      endcase
    end
    if (d == 0) begin
      m_hx += MOVE * (int'(sr) - int'(sl));
      m_hy += MOVE * (int'(sd) - int'(su));
    end else if (ax) begin
      m_hx += MOVE * (int'(sr) - int'(sl));
      m_hy = ng;
    end else begin
      m_hx = ng;
      m_hy += MOVE * (int'(sd) - int'(su));
    end
    if (m_hx < int'(x0) * SC) m_hx = int'(x0) * SC;
    if (m_hx > (int'(x1) - PW) * SC) m_hx = (int'(x1) - PW) * SC;
    if (m_hy < int'(y0) * SC) m_hy = int'(y0) * SC;
    if (m_hy > (int'(y1) - PH) * SC) m_hy = (int'(y1) - PH) * SC;
    m_prev = d;
    e.ms = m_st;
    e.og = (m_st == 1) ? 1 : 0;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (player_pos_x !== 10'(e.px) || player_pos_y !== 10'(e.py) ||
          on_ground !== 1'(e.og) || motion_state !== 2'(e.ms) ||
          player_w !== 10'd30 || player_h !== 10'd30) begin
        failures++;
        $display("FAIL scoreboard t=%0t got pos=(%0d,%0d) og=%0d st=%0d size=(%0d,%0d) expected pos=(%0d,%0d) og=%0d st=%0d size=(30,30)",
                 $time, player_pos_x, player_pos_y, on_ground, motion_state, player_w, player_h,
                 e.px, e.py, e.og, e.ms);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (int'(player_pos_y) < trk_min_y) trk_min_y = int'(player_pos_y);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int st, input int limit, input string name);
    int n = 0;
    while (int'(motion_state) != st && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (int'(motion_state) != st) begin
      failures++;
      $display("FAIL %s: state %0d after %0d ticks, expected %0d", name, motion_state, n, st);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; su = 0; sd = 0; sl = 0; sr = 0;
    x0 = 100; y0 = 100; x1 = 400; y1 = 400; gdir = 0; col = 0; col_v = 0;
    trk_min_y = 1023;
    @(negedge clk);
    tick(); tick();
    check("reset_x", player_pos_x, 320);
    check("reset_y", player_pos_y, 240);
    check("reset_state", motion_state, 0);
    check("reset_on_ground", on_ground, 0);
    reset = 1'b0;

    sr = 1; repeat (10) tick(); sr = 0; tick();
    check("free_right_x", player_pos_x, 331);
    check("free_right_y", player_pos_y, 240);
    check("free_state", motion_state, 0);

    do_reset(); gdir = 3;
    wait_state(3, 5, "down_fall_start");
    wait_state(1, 200, "down_land");
    tick();
    check("down_land_y", player_pos_y, 370);
    check("down_on_ground", on_ground, 1);

    su = 1; wait_state(2, 3, "jump_start");
    trk_min_y = 1023;
    wait_state(3, 100, "jump_to_fall"); su = 0;
    wait_state(1, 200, "jump_reland");
    tick();
    check("jump_apex_y", trk_min_y, 290);
    check("jump_reland_y", player_pos_y, 370);

    do_reset(); gdir = 1;
    wait_state(1, 200, "up_land");
    tick();
    check("up_land_y", player_pos_y, 100);
    su = 1; repeat (5) tick();
    check("up_key_ignored", motion_state, 1);
    su = 0; sd = 1; tick();
    check("down_key_jumps", motion_state, 2);
    sd = 0;

    do_reset(); gdir = 2; col = 350; col_v = 1;
    wait_state(1, 50, "right_collider_land");
    tick();
    check("collider_land_x", player_pos_x, 320);
    col_v = 0; tick();
    check("collider_drop_state", motion_state, 3);
    wait_state(1, 200, "right_box_land");
    tick();
    check("box_land_x", player_pos_x, 370);

    do_reset(); gdir = 3;
    wait_state(1, 200, "pre_reset_land");
    su = 1; tick(); tick();
    check("jump_before_reset", motion_state, 2);
    reset = 1; tick();
    check("reset_mid_jump_x", player_pos_x, 320);
    check("reset_mid_jump_y", player_pos_y, 240);
    check("reset_mid_jump_state", motion_state, 0);
    reset = 0; su = 0; tick();
    check("post_reset_dir_change", motion_state, 3);
    wait_state(1, 200, "reland_before_switch");
    su = 1; tick(); tick();
    check("jump_before_switch", motion_state, 2);
    gdir = 4; tick();
    check("dir_switch_falling", motion_state, 3);
    su = 0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) gdir = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) su = ~su;
      if ($urandom_range(0, 7) == 0) sd = ~sd;
      if ($urandom_range(0, 7) == 0) sl = ~sl;
      if ($urandom_range(0, 7) == 0) sr = ~sr;
      if ($urandom_range(0, 99) == 0) begin
        x0 = 10'($urandom_range(50, 150)); x1 = 10'($urandom_range(350, 450));
        y0 = 10'($urandom_range(50, 150)); y1 = 10'($urandom_range(350, 450));
      end
      if ($urandom_range(0, 29) == 0) begin
        col   = 10'($urandom_range(0, 511));
        col_v = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    tick(); tick();
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
